// File: rtl/rgb_cmp_pkg.sv
// -----------------------------------------------------------------------------
// rgb_cmp_pkg
// Shared types for the RGB compare/PWM block:
//   state_e  : controller FSM states (IDLE, CAPTURE, SHOW)
//   result_e : compare result encoding driven on the result port
//   result_to_rgb() : maps a result to its {red, green, blue} channel select
// -----------------------------------------------------------------------------
package rgb_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHOW    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_LT   = 2'b01,
    RES_EQ   = 2'b10,
    RES_GT   = 2'b11
  } result_e;

  // One-hot {red, green, blue}; RES_NONE selects nothing so the LEDs stay dark.
  function automatic logic [2:0] result_to_rgb(input result_e res);
    logic [2:0] sel;
    sel = 3'b000;
    case (res)
      RES_LT:  sel = 3'b100;
      RES_EQ:  sel = 3'b010;
      RES_GT:  sel = 3'b001;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rgb_compare_pwm_pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Free-running PWM_BITS counter with synchronous clear and count enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear of the counter (wins over en_i)
//   en_i       : advance the counter by one, wrapping modulo 2^PWM_BITS
//   duty_i     : brightness threshold
//   on_o       : cnt < duty_i (combinational from the counter register)
// -----------------------------------------------------------------------------
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                on_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;  // natural wrap at 2^PWM_BITS
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // duty = 0 never fires; duty = max misses only the cnt = max cycle.
  assign on_o = (cnt_q < duty_i);

endmodule

// File: rtl/rgb_compare_pwm.sv
// -----------------------------------------------------------------------------
// rgb_compare_pwm
// Samples two unsigned operands on a start strobe, classifies them as
// less/equal/greater, then drives exactly one RGB LED with a PWM waveform of
// programmable brightness for HOLD_CYCLES cycles.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, honoured only in IDLE
//   a, b [WIDTH]    : unsigned operands, sampled with start
//   duty [PWM_BITS] : brightness, sampled with start
//   red/green/blue  : registered PWM-gated LED outputs (a<b / a==b / a>b)
//   result [2]      : 00 none, 01 less, 10 equal, 11 greater; held in IDLE
//   busy            : high in CAPTURE and SHOW
//
// Build option: define RGB_CMP_BLINK_EN to additionally gate green with a
// blink phase of BLINK_PERIOD cycles on / BLINK_PERIOD cycles off, counted
// from SHOW entry. Without it green is steady PWM and no blink logic exists.
// -----------------------------------------------------------------------------
module rgb_compare_pwm
  import rgb_cmp_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int PWM_BITS     = 8,
  parameter int HOLD_CYCLES  = 1024,
  parameter int BLINK_PERIOD = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [PWM_BITS-1:0] duty,
  output logic                red,
  output logic                green,
  output logic                blue,
  output logic [1:0]          result,
  output logic                busy
);

  // Hold counter runs 0 .. HOLD_CYCLES-1.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (WIDTH < 1)        begin : g_bad_width $error("WIDTH must be >= 1"); end
  if (HOLD_CYCLES < 1)  begin : g_bad_hold  $error("HOLD_CYCLES must be >= 1"); end
  if (BLINK_PERIOD < 1) begin : g_bad_blink $error("BLINK_PERIOD must be >= 1"); end

  state_e              state_q,  state_d;
  logic [WIDTH-1:0]    a_q,      a_d;
  logic [WIDTH-1:0]    b_q,      b_d;
  logic [PWM_BITS-1:0] duty_q,   duty_d;
  result_e             result_q, result_d;
  logic [HOLD_W-1:0]   hold_q,   hold_d;
  logic [2:0]          led_q,    led_d;

  logic    pwm_clr;
  logic    pwm_en;
  logic    pwm_on;
  logic    hold_last;
  result_e cmp_res;
  logic [2:0] blink_mask;

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (pwm_clr),
    .en_i   (pwm_en),
    .duty_i (duty_q),
    .on_o   (pwm_on)
  );

  assign cmp_res   = (a_q < b_q)  ? RES_LT :
                     (a_q == b_q) ? RES_EQ : RES_GT;
  assign hold_last = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

`ifdef RGB_CMP_BLINK_EN
  logic blink_on;
  // Phase 1 for hold counts [0, P), 0 for [P, 2P), repeating.
  assign blink_on   = ((32'(hold_q) / BLINK_PERIOD) % 2) == 0;
  assign blink_mask = {1'b1, blink_on, 1'b1};
`else
  assign blink_mask = 3'b111;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    duty_d   = duty_q;
    result_d = result_q;
    hold_d   = hold_q;
    led_d    = 3'b000;
    pwm_clr  = 1'b0;
    pwm_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          duty_d  = duty;
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        result_d = cmp_res;
        hold_d   = '0;
        pwm_clr  = 1'b1;
        state_d  = SHOW;
      end

      SHOW: begin
        pwm_en = 1'b1;
        if (hold_last) begin
          // LEDs register 0 on the same edge the FSM lands in IDLE.
          hold_d  = '0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
          led_d  = result_to_rgb(result_q) & {3{pwm_on}} & blink_mask;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      duty_q   <= '0;
      result_q <= RES_NONE;
      hold_q   <= '0;
      led_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      duty_q   <= duty_d;
      result_q <= result_d;
      hold_q   <= hold_d;
      led_q    <= led_d;
    end
  end

  assign {red, green, blue} = led_q;
  assign result             = result_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_rgb_compare_pwm.sv
// -----------------------------------------------------------------------------
// tb_rgb_compare_pwm
// Directed bench for rgb_compare_pwm with HOLD_CYCLES = 512 and PWM_BITS = 8.
// Each window exposes 511 registered LED samples (pwm_cnt 0..510), so the
// expected on-count of the selected channel is exactly 2*duty (duty <= 255).
// -----------------------------------------------------------------------------
module tb_rgb_compare_pwm;

  localparam int WIDTH        = 4;
  localparam int PWM_BITS     = 8;
  localparam int HOLD_CYCLES  = 512;
  localparam int BLINK_PERIOD = 256;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [PWM_BITS-1:0] duty;
  logic                red;
  logic                green;
  logic                blue;
  logic [1:0]          result;
  logic                busy;

  int vectors     = 0;
  int miscompares = 0;

  rgb_compare_pwm #(
    .WIDTH        (WIDTH),
    .PWM_BITS     (PWM_BITS),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .BLINK_PERIOD (BLINK_PERIOD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .duty   (duty),
    .red    (red),
    .green  (green),
    .blue   (blue),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in IDLE. Returns at the negedge after
  // the FSM is back in IDLE, so a following call starts back-to-back.
  // poke != 0 pulses start with different operands in the middle of SHOW.
  task automatic run_window(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                            input logic [7:0] td, input logic [1:0] exp_res, input bit poke);
    int on_r, on_g, on_b, multi, not_busy, exp_on, exp_g;
    logic [2:0] sel;
    on_r = 0; on_g = 0; on_b = 0; multi = 0; not_busy = 0;

    a = ta; b = tb; duty = td; start = 1'b1;
    @(negedge clk);                       // after edge k
    start = 1'b0;
    check({tag, ".busy_k"}, 32'(busy), 32'd1);
    @(negedge clk);                       // after edge k+1
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".led_k1"}, 32'({red, green, blue}), 32'd0);

    for (int i = 0; i < HOLD_CYCLES - 1; i++) begin
      @(negedge clk);                     // after edges k+2 .. k+HOLD
      on_r += int'(red);
      on_g += int'(green);
      on_b += int'(blue);
      if (int'(red) + int'(green) + int'(blue) > 1) multi++;
      if (!busy) not_busy++;
      if (poke && i == 100) begin
        a = 4'd15; b = 4'd0; duty = 8'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (poke && i == 200) check({tag, ".result_mid"}, 32'(result), 32'(exp_res));
    end

    @(negedge clk);                       // after edge k+1+HOLD
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".led_end"}, 32'({red, green, blue}), 32'd0);
    check({tag, ".result_hold"}, 32'(result), 32'(exp_res));

    case (exp_res)
      2'b01:   sel = 3'b100;
      2'b10:   sel = 3'b010;
      2'b11:   sel = 3'b001;
      default: sel = 3'b000;
    endcase
    exp_on = 2 * int'(td);
`ifdef RGB_CMP_BLINK_EN
    exp_g = int'(td);                     // only hold counts 0..255 are lit
`else
    exp_g = exp_on;
`endif
    check({tag, ".on_red"},   32'(on_r), sel[2] ? 32'(exp_on) : 32'd0);
    check({tag, ".on_green"}, 32'(on_g), sel[1] ? 32'(exp_g)  : 32'd0);
    check({tag, ".on_blue"},  32'(on_b), sel[0] ? 32'(exp_on) : 32'd0);
    check({tag, ".onehot"},   32'(multi), 32'd0);
    check({tag, ".busy_show"}, 32'(not_busy), 32'd0);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic [7:0] rd;
    logic [1:0] rres;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; duty = '0;
    repeat (3) @(negedge clk);
    check("reset.leds",   32'({red, green, blue}), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.busy",   32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_window("lt",   4'd3,  4'd9, 8'd255, 2'b01, 1'b0);   // red 510
    run_window("eq",   4'd7,  4'd7, 8'd128, 2'b10, 1'b0);   // green 256
    run_window("gt",   4'd15, 4'd0, 8'd0,   2'b11, 1'b0);   // blue dark
    run_window("poke", 4'd3,  4'd9, 8'd255, 2'b01, 1'b1);   // mid-SHOW start ignored
    run_window("next", 4'd9,  4'd3, 8'd64,  2'b11, 1'b0);   // back-to-back accepted

    // Asynchronous reset in the middle of SHOW.
    a = 4'd2; b = 4'd5; duty = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst.busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst.leds",   32'({red, green, blue}), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.busy",   32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.idle", 32'(busy), 32'd0);
    run_window("post_rst", 4'd2, 4'd2, 8'd255, 2'b10, 1'b0);  // green 510

    // Random operands and brightness against a plain unsigned compare.
    for (int n = 0; n < 40; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rd = 8'($urandom_range(0, 255));
      rres = (ra < rb) ? 2'b01 : (ra == rb) ? 2'b10 : 2'b11;
      run_window($sformatf("rnd%0d", n), ra, rb, rd, rres, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
